// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: hex-to-segment table and segment bus indexing.
// Latency: n/a (constants only).
// Backpressure: n/a.
//
// Segment bus order is {g,f,e,d,c,b,a}; bit SEG_MSB is segment g, bit 0 is segment a.
package seg7_pkg;

  // Index of the most significant segment bit (segment g).
  localparam int SEG_MSB = 6;

  // Active-high segment patterns; element [h] is the glyph for hex digit h.
  // The first listed entry is element [15] (F), the last is element [0] (0).
  localparam logic [15:0][SEG_MSB:0] HEX_SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// Hex nibble to active-high 7-segment pattern.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   i_HEX  in   4  hex digit
//   o_SEG  out  7  segments {g,f,e,d,c,b,a}, 1 = lit
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0]       i_HEX,
  output logic [SEG_MSB:0] o_SEG
);

  assign o_SEG = HEX_SEG_TABLE[i_HEX];

endmodule

// File: rtl/seg7_mux_display.sv
// Time-multiplexed N-digit 7-segment driver with LZ blanking and per-frame value snapshot.
// Latency: outputs registered, 1 clock behind the scan counters.
// Backpressure: none; free-running scan, i_ENABLE only gates digit selects.
//
// Ports:
//   i_CLK, i_RST_N          clock, async active-low reset (release assumed synchronised upstream)
//   i_VALUE [4N-1:0]        packed hex digits, [3:0] = digit 0
//   i_DP    [N-1:0]         decimal point per digit, 1 = lit
//   i_ENABLE                0 = all digits off, counters keep running
//   o_SEG [6:0], o_DP       segments {g,f,e,d,c,b,a} and dp, polarity per SEG_ACTIVE_LOW
//   o_DIGIT [N-1:0]         one-hot digit select, polarity per DIG_ACTIVE_LOW
//   o_FRAME_DONE            1-clock pulse after the scan wraps back to digit 0
module seg7_mux_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter int BLANK_CLKS     = 250,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ       = 1'b1
) (
  input  logic                    i_CLK,
  input  logic                    i_RST_N,
  input  logic [4*NUM_DIGITS-1:0] i_VALUE,
  input  logic [NUM_DIGITS-1:0]   i_DP,
  input  logic                    i_ENABLE,
  output logic [SEG_MSB:0]        o_SEG,
  output logic                    o_DP,
  output logic [NUM_DIGITS-1:0]   o_DIGIT,
  output logic                    o_FRAME_DONE
);

  localparam int PS_W  = $clog2(CLKS_PER_DIGIT);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(CLKS_PER_DIGIT - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [SEG_MSB:0]      SEG_OFF  = {(SEG_MSB+1){SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  logic [PS_W-1:0]         prescaler_q, prescaler_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic                    load_q, load_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [SEG_MSB:0]        seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   digit_q, digit_d;
  logic                    frame_done_q, frame_done_d;

  logic                    slot_end, frame_wrap;
  logic                    above_zero;
  logic [NUM_DIGITS-1:0]   lz_blank;
  logic [3:0]              cur_nib;
  logic                    cur_dp, cur_blank;
  logic [NUM_DIGITS-1:0]   digit_hot;
  logic [SEG_MSB:0]        dec_seg, seg_hi;

  // Scan counters and shadow load. The shadow is only refreshed on the first clock
  // after reset or on the wrap to digit 0, so a frame never mixes two values.
  always_comb begin
    slot_end     = (prescaler_q == PS_LAST);
    frame_wrap   = slot_end && (index_q == IDX_LAST);
    prescaler_d  = slot_end ? '0 : prescaler_q + 1'b1;
    index_d      = index_q;
    if (slot_end) begin
      index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
    end
    load_d       = 1'b0;
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    if (load_q || frame_wrap) begin
      shadow_val_d = i_VALUE;
      shadow_dp_d  = i_DP;
    end
  end

  // Leading-zero mask: walk down from the top digit while everything seen is zero.
  // Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    lz_blank   = '0;
    above_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      above_zero  = above_zero && (shadow_val_q[4*k +: 4] == 4'h0);
      lz_blank[k] = BLANK_LZ && above_zero;
    end
  end

  // Current-digit selection, written as a compare loop so non-power-of-two
  // digit counts never index past the shadow.
  always_comb begin
    cur_nib   = 4'h0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    digit_hot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index_q == IDX_W'(k)) begin
        cur_nib      = shadow_val_q[4*k +: 4];
        cur_dp       = shadow_dp_q[k];
        cur_blank    = lz_blank[k];
        digit_hot[k] = 1'b1;
      end
    end
  end

  seg7_hex_decoder u_dec (
    .i_HEX (cur_nib),
    .o_SEG (dec_seg)
  );

  // Registered outputs; the first BLANK_CLKS clocks of each slot keep all digits
  // off so the previous digit's segments cannot ghost onto the new one.
  always_comb begin
    seg_hi       = cur_blank ? '0 : dec_seg;
    seg_d        = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
    dp_d         = SEG_ACTIVE_LOW ? ~cur_dp : cur_dp;
    digit_d      = DIG_OFF;
    if (i_ENABLE && (int'(prescaler_q) >= BLANK_CLKS)) begin
      digit_d = DIG_ACTIVE_LOW ? ~digit_hot : digit_hot;
    end
    frame_done_d = frame_wrap;
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      prescaler_q  <= '0;
      index_q      <= '0;
      load_q       <= 1'b1;
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      digit_q      <= DIG_OFF;
      frame_done_q <= 1'b0;
    end else begin
      prescaler_q  <= prescaler_d;
      index_q      <= index_d;
      load_q       <= load_d;
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign o_SEG        = seg_q;
  assign o_DP         = dp_q;
  assign o_DIGIT      = digit_q;
  assign o_FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg7_mux_display.sv
// Directed bench for seg7_mux_display: 4 digits, 4-clock slots, 1 blank clock, active-low.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg7_mux_display;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        en;

  logic [6:0]  seg, seg_nolz;
  logic        dp_o, dp_nolz;
  logic [3:0]  dig, dig_nolz;
  logic        fd, fd_nolz;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_mux_display #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .BLANK_CLKS(1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b1)
  ) u_dut (
    .i_CLK(clk), .i_RST_N(rst_n), .i_VALUE(value), .i_DP(dp_in), .i_ENABLE(en),
    .o_SEG(seg), .o_DP(dp_o), .o_DIGIT(dig), .o_FRAME_DONE(fd)
  );

  seg7_mux_display #(
    .NUM_DIGITS(4), .CLKS_PER_DIGIT(4), .BLANK_CLKS(1),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1), .BLANK_LZ(1'b0)
  ) u_dut_nolz (
    .i_CLK(clk), .i_RST_N(rst_n), .i_VALUE(value), .i_DP(dp_in), .i_ENABLE(en),
    .o_SEG(seg_nolz), .o_DP(dp_nolz), .o_DIGIT(dig_nolz), .o_FRAME_DONE(fd_nolz)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One output clock: digit p of slot d. Segments are only checked while a digit is lit.
  task automatic step(input string tag, input int d, input int p, input bit on,
                      input logic [6:0] exp_seg, input logic [6:0] exp_seg_nolz,
                      input bit dp_lit);
    logic [3:0] exp_dig;
    @(negedge clk);
    exp_dig = (on && p != 0) ? ~(4'b0001 << d) : 4'hF;
    chk($sformatf("%s d%0d p%0d digit", tag, d, p), dig, exp_dig);
    chk($sformatf("%s d%0d p%0d digit_nolz", tag, d, p), dig_nolz, exp_dig);
    chk($sformatf("%s d%0d p%0d frame_done", tag, d, p), fd, (d == 3 && p == 3));
    chk($sformatf("%s d%0d p%0d frame_done_nolz", tag, d, p), fd_nolz, (d == 3 && p == 3));
    if (on && p != 0) begin
      chk($sformatf("%s d%0d p%0d seg", tag, d, p), seg, exp_seg);
      chk($sformatf("%s d%0d p%0d seg_nolz", tag, d, p), seg_nolz, exp_seg_nolz);
      chk($sformatf("%s d%0d p%0d dp", tag, d, p), dp_o, !dp_lit);
    end
  endtask

  // segs / segs_nolz are written most significant digit first: {d3, d2, d1, d0}.
  task automatic check_frame(input string tag, input logic [3:0][6:0] segs,
                             input logic [3:0][6:0] segs_nolz, input logic [3:0] dps);
    for (int d = 0; d < 4; d++)
      for (int p = 0; p < 4; p++)
        step(tag, d, p, 1'b1, segs[d], segs_nolz[d], dps[d]);
  endtask

  task automatic check_inactive(input string tag);
    chk({tag, " seg"}, seg, 7'h7F);
    chk({tag, " digit"}, dig, 4'hF);
    chk({tag, " dp"}, dp_o, 1'b1);
    chk({tag, " frame_done"}, fd, 1'b0);
    chk({tag, " digit_nolz"}, dig_nolz, 4'hF);
  endtask

  // Active-low glyphs used below: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00
  // A:08 b:03 C:46 d:21, blank:7F.
  logic [3:0][6:0] s1234;

  initial begin
    s1234 = {7'h79, 7'h24, 7'h30, 7'h19};
    rst_n = 1'b1;
    value = 16'h1234;
    dp_in = 4'b0000;
    en    = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_inactive("reset");
    rst_n = 1'b0;
    @(negedge clk);
    check_inactive("reset_hold");
    rst_n = 1'b1;

    // Frame 1: first value after reset release.
    check_frame("f1234", s1234, s1234, 4'b0000);

    // Frame 2: value changes while digit 1 is on; this frame must not notice.
    for (int p = 0; p < 4; p++) step("snap", 0, p, 1'b1, 7'h19, 7'h19, 1'b0);
    step("snap", 1, 0, 1'b1, 7'h30, 7'h30, 1'b0);
    step("snap", 1, 1, 1'b1, 7'h30, 7'h30, 1'b0);
    value = 16'hABCD;
    step("snap", 1, 2, 1'b1, 7'h30, 7'h30, 1'b0);
    step("snap", 1, 3, 1'b1, 7'h30, 7'h30, 1'b0);
    for (int p = 0; p < 4; p++) step("snap", 2, p, 1'b1, 7'h24, 7'h24, 1'b0);
    for (int p = 0; p < 4; p++) step("snap", 3, p, 1'b1, 7'h79, 7'h79, 1'b0);

    // Frame 3 shows the new snapshot; inputs for frame 4 are set now.
    value = 16'h0050;
    dp_in = 4'b0100;
    check_frame("fabcd", {7'h08, 7'h03, 7'h46, 7'h21}, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b0000);

    value = 16'h0000;
    dp_in = 4'b0000;
    check_frame("lz0050", {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h40, 7'h40, 7'h12, 7'h40}, 4'b0100);

    value = 16'h1234;
    check_frame("lz0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b0000);

    // Frame 6: enable low for 10 clocks; scan and frame_done keep their timing.
    for (int i = 0; i < 16; i++) begin
      if (i == 0)  en = 1'b0;
      if (i == 10) en = 1'b1;
      step("enable", i / 4, i % 4, (i >= 10), s1234[i / 4], s1234[i / 4], 1'b0);
    end

    // Frame 7: reset in the middle of digit 2's slot.
    for (int p = 0; p < 4; p++) step("prerst", 0, p, 1'b1, 7'h19, 7'h19, 1'b0);
    for (int p = 0; p < 4; p++) step("prerst", 1, p, 1'b1, 7'h30, 7'h30, 1'b0);
    step("prerst", 2, 0, 1'b1, 7'h24, 7'h24, 1'b0);
    step("prerst", 2, 1, 1'b1, 7'h24, 7'h24, 1'b0);
    value = 16'h8765;
    dp_in = 4'b0001;
    rst_n = 1'b0;
    #1;
    check_inactive("midrst_async");
    repeat (2) @(negedge clk);
    check_inactive("midrst_hold");
    rst_n = 1'b1;

    check_frame("postrst", {7'h00, 7'h78, 7'h02, 7'h12}, {7'h00, 7'h78, 7'h02, 7'h12}, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
